// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus controller: FSM states,
// load/store type encodings and the store lane/alignment functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LD_LW  = 3'b111;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LH  = 3'b100;

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;
    localparam logic [1:0] ST_SW = 2'b11;

    // Reserved store types drive no lanes, but the bus cycle is still run.
    function automatic logic [3:0] st_byteen(input logic [1:0] st, input logic [1:0] lo);
        case (st)
            ST_SB:   st_byteen = 4'b0001 << lo;
            ST_SH:   st_byteen = lo[1] ? 4'b1100 : 4'b0011;
            ST_SW:   st_byteen = 4'b1111;
            default: st_byteen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] st_wdata(input logic [1:0] st, input logic [31:0] wd);
        case (st)
            ST_SB:   st_wdata = {4{wd[7:0]}};
            ST_SH:   st_wdata = {2{wd[15:0]}};
            default: st_wdata = wd;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic we, input logic [2:0] ld,
                                           input logic [1:0] st, input logic [1:0] lo);
        is_misaligned = 1'b0;
        if (we) begin
            case (st)
                ST_SW:   is_misaligned = (lo != 2'b00);
                ST_SH:   is_misaligned = lo[0];
                default: is_misaligned = 1'b0;
            endcase
        end else begin
            case (ld)
                LD_LW:          is_misaligned = (lo != 2'b00);
                LD_LH, LD_LHU:  is_misaligned = lo[0];
                default:        is_misaligned = 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and extends it
// according to the load type; reserved load types yield zero.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by zero/sign extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = addr_lo[1] ? word[31:16] : word[15:0];
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        case (ld_type)
            LD_LW:   data = word;
            LD_LBU:  data = {24'h000000, byte_s};
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LHU:  data = {16'h0000, half_s};
            LD_LH:   data = {{16{half_s[15]}}, half_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store unit bus controller: alignment check, single
// outstanding bus transfer with timeout, and one-cycle completion pulse.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_ld_type,
    input  logic [1:0]  mem_st_type,
    output logic        mem_stall,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        we_q, we_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_bus_q, exc_bus_d;
    logic [31:0] align_s;
    logic        misaligned_s;

    lsu_load_align u_align (
        .word    (bus_rdata),
        .addr_lo (addr_lo_q),
        .ld_type (ld_type_q),
        .data    (align_s)
    );

    // Next-state, request capture, timeout and combinational handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        addr_lo_d    = addr_lo_q;
        we_d         = we_q;
        ld_type_d    = ld_type_q;
        byteen_d     = byteen_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        exc_bus_d    = exc_bus_q;
        mem_stall    = 1'b0;
        exc_adel     = 1'b0;
        exc_ades     = 1'b0;
        misaligned_s = is_misaligned(mem_we, mem_ld_type, mem_st_type, mem_addr[1:0]);
        case (state_q)
            S_IDLE: begin
                if (mem_valid && misaligned_s) begin
                    exc_adel = ~mem_we;
                    exc_ades = mem_we;
                end else if (mem_valid) begin
                    mem_stall = 1'b1;
                    state_d   = S_BUSY;
                    cnt_d     = 8'd0;
                    addr_d    = {mem_addr[31:2], 2'b00};
                    addr_lo_d = mem_addr[1:0];
                    we_d      = mem_we;
                    ld_type_d = mem_ld_type;
                    byteen_d  = mem_we ? st_byteen(mem_st_type, mem_addr[1:0]) : 4'b1111;
                    wdata_d   = mem_we ? st_wdata(mem_st_type, mem_wdata) : 32'h0000_0000;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                // An ack on the final wait cycle beats the timeout.
                if (bus_ack) begin
                    state_d   = S_RESP;
                    rdata_d   = we_q ? 32'h0000_0000 : align_s;
                    exc_bus_d = 1'b0;
                end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
                    state_d   = S_RESP;
                    rdata_d   = 32'h0000_0000;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                exc_bus_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset abandons any transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 32'h0000_0000;
            addr_lo_q <= 2'b00;
            we_q      <= 1'b0;
            ld_type_q <= 3'b000;
            byteen_q  <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            exc_bus_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            addr_lo_q <= addr_lo_d;
            we_q      <= we_d;
            ld_type_q <= ld_type_d;
            byteen_q  <= byteen_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            exc_bus_q <= exc_bus_d;
        end
    end

    assign bus_req    = (state_q == S_BUSY);
    assign mem_rvalid = (state_q == S_RESP);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_byteen = byteen_q;
    assign bus_wdata  = wdata_q;
    assign mem_rdata  = rdata_q;
    assign exc_bus    = exc_bus_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomised self-checking bench for lsu_bus_ctrl against a transaction-level
// model of alignment, lane enables, load extension and the bus timeout.
module tb_lsu_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_st_type;
    logic        mem_stall, mem_rvalid, exc_adel, exc_ades, exc_bus;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;

    int n_checks = 0;
    int n_errors = 0;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ld_type(mem_ld_type), .mem_st_type(mem_st_type),
        .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes; reserved encodings behave as byte-sized.
    function automatic int acc_size(input logic we, input logic [2:0] ld, input logic [1:0] st);
        if (we) return (st == 2'b11) ? 4 : (st == 2'b10) ? 2 : 1;
        return (ld == 3'b111) ? 4 : (ld == 3'b011 || ld == 3'b100) ? 2 : 1;
    endfunction

    function automatic logic [3:0] exp_byteen(input logic we, input logic [1:0] st, input logic [31:0] a);
        int lo = int'(a % 4);
        if (!we) return 4'hF;
        if (st == 2'b01) return 4'(1 << lo);
        if (st == 2'b10) return 4'(3 << (lo / 2 * 2));
        if (st == 2'b11) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] st, input logic [31:0] wd);
        logic [31:0] b = wd & 32'hFF;
        logic [31:0] h = wd & 32'hFFFF;
        if (st == 2'b01) return b * 32'h0101_0101;
        if (st == 2'b10) return h * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] w = rd >> (8 * (a % 4));
        logic [31:0] b = w & 32'hFF;
        logic [31:0] h = w & 32'hFFFF;
        case (ld)
            3'b111:  return rd;
            3'b001:  return b;
            3'b010:  return (b >= 32'h80) ? b - 32'h100 : b;
            3'b011:  return h;
            3'b100:  return (h >= 32'h8000) ? h - 32'h1_0000 : h;
            default: return 32'h0;
        endcase
    endfunction

    // One MEM-stage access; ack_dly = BUSY cycle index carrying the ack, -1 = never.
    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] ld, input logic [1:0] st,
                             input int ack_dly, input logic [31:0] rd);
        bit ok_ack;
        int nbusy;
        @(negedge clk);
        chk("rvalid_before", 32'(mem_rvalid), 32'd0);
        mem_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
        mem_ld_type = ld; mem_st_type = st; bus_ack = 1'b0;
        #1;
        if (a % acc_size(we, ld, st) != 0) begin
            chk("exc_adel", 32'(exc_adel), 32'(!we));
            chk("exc_ades", 32'(exc_ades), 32'(we));
            chk("stall_mis", 32'(mem_stall), 32'd0);
            chk("req_mis", 32'(bus_req), 32'd0);
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            chk("req_after_mis", 32'(bus_req), 32'd0);
            return;
        end
        chk("stall_start", 32'(mem_stall), 32'd1);
        chk("exc_none", {30'd0, exc_adel, exc_ades}, 32'd0);
        ok_ack = (ack_dly >= 0 && ack_dly < TO);
        nbusy  = ok_ack ? ack_dly + 1 : TO;
        for (int i = 0; i < nbusy; i++) begin
            @(negedge clk);
            bus_ack   = ok_ack && (i == ack_dly);
            bus_rdata = bus_ack ? rd : $urandom;
            #1;
            chk("busy_req", 32'(bus_req), 32'd1);
            chk("busy_stall", 32'(mem_stall), 32'd1);
            chk("busy_rvalid", 32'(mem_rvalid), 32'd0);
            chk("bus_addr", bus_addr, a & ~32'd3);
            chk("bus_we", 32'(bus_we), 32'(we));
            chk("bus_byteen", 32'(bus_byteen), 32'(exp_byteen(we, st, a)));
            if (we && st != 2'b00) chk("bus_wdata", bus_wdata, exp_wdata(st, wd));
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        #1;
        chk("resp_rvalid", 32'(mem_rvalid), 32'd1);
        chk("resp_stall", 32'(mem_stall), 32'd0);
        chk("resp_req", 32'(bus_req), 32'd0);
        chk("resp_exc_bus", 32'(exc_bus), 32'(!ok_ack));
        chk("resp_rdata", mem_rdata, (we || !ok_ack) ? 32'd0 : exp_load(ld, a, rd));
        mem_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_ld_type = 3'd0; mem_st_type = 2'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #12;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
        chk("rst_byteen", 32'(bus_byteen), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_exc_bus", 32'(exc_bus), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed scenarios from the requirements.
        do_access(1'b0, 32'h0000_0003, 32'd0, 3'b010, 2'b00, 2, 32'h80FF_FFFF);
        do_access(1'b1, 32'h0000_0002, 32'h0000_BEEF, 3'b000, 2'b10, 0, 32'd0);
        do_access(1'b0, 32'h0000_0006, 32'd0, 3'b111, 2'b00, 0, 32'd0);
        do_access(1'b0, 32'h0000_0040, 32'd0, 3'b111, 2'b00, -1, 32'd0);
        do_access(1'b0, 32'h0000_0002, 32'd0, 3'b011, 2'b00, 0, 32'h1234_5678);
        do_access(1'b0, 32'h0000_0010, 32'd0, 3'b111, 2'b00, TO - 1, 32'hCAFE_F00D);
        do_access(1'b1, 32'h0000_0021, 32'h1111_22AB, 3'b000, 2'b00, 1, 32'd0);

        // Reset in the middle of a transfer, then a stray ack.
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100; mem_ld_type = 3'b111;
        @(negedge clk);
        #1;
        chk("mid_req", 32'(bus_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_rvalid", 32'(mem_rvalid), 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            chk("stray_rvalid", 32'(mem_rvalid), 32'd0);
            chk("stray_req", 32'(bus_req), 32'd0);
        end

        // Randomised accesses, back to back.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
            do_access(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), int'($urandom_range(0, 6)) - 1, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus wait cycles before a bus error; legal range 1..255, 8-bit counter.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 mem_valid  in  1  MEM stage holds a load/store this cycle.
REQ-006 mem_we  in  1  1 = store, 0 = load.
REQ-007 mem_addr  in  32  byte address.
REQ-008 mem_wdata  in  32  store data, right-aligned.
REQ-009 mem_ld_type  in  3  111 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; others reserved.
REQ-010 mem_st_type  in  2  01 sb, 10 sh, 11 sw; 00 reserved.
REQ-011 mem_stall  out  1  freeze pipeline.
REQ-012 mem_rvalid  out  1  one-cycle completion pulse (loads and stores).
REQ-013 mem_rdata  out  32  extended load result, valid while mem_rvalid.
REQ-014 exc_adel / exc_ades  out  1 each  misaligned load / store.
REQ-015 exc_bus  out  1  bus timeout, valid while mem_rvalid.
REQ-016 bus_req, bus_we  out  1 each  request and direction.
REQ-017 bus_addr  out  32  word address, bits [1:0] = 00.
REQ-018 bus_byteen  out  4  byte-lane enables.
REQ-019 bus_wdata  out  32  lane-replicated store data.
REQ-020 bus_ack  in  1  one-cycle completion from slave.
REQ-021 bus_rdata  in  32  read word, valid with bus_ack.

Function
REQ-022 SHALL implement a 3-state FSM: IDLE, BUSY, RESP.
REQ-023 Misaligned: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0.
REQ-024 IDLE with mem_valid and misaligned: combinational exc_adel (load) or exc_ades (store) in the same cycle; mem_stall=0; no bus request; stay IDLE.
REQ-025 IDLE with mem_valid and aligned: mem_stall=1 combinationally; latch addr, type, we, data; go to BUSY next edge.
REQ-026 BUSY: bus_req=1; bus_addr, bus_we, bus_byteen and bus_wdata come from registers and stay stable until the ack; mem_stall=1.
REQ-027 bus_byteen: sb = 0001<<addr[1:0]; sh = 0011<<(2*addr[1]); sw and all loads = 1111.
REQ-028 bus_wdata: sb = byte replicated 4x; sh = halfword replicated 2x; sw = unchanged.
REQ-029 BUSY with bus_ack: latch the extended load data, go to RESP; bus_req drops on the next cycle.
REQ-030 Extension: select the byte by addr[1:0] and the halfword by addr[1]; lbu/lhu zero-extend, lb/lh sign-extend, lw pass-through, reserved ld_type gives 0 (the bus read is still performed).
REQ-031 BUSY counter: cleared on entry, increments each cycle without ack; at count==TIMEOUT_CYCLES go to RESP with exc_bus=1 and rdata=0.
REQ-032 bus_ack in the same cycle as the timeout: the ack wins and exc_bus=0.
REQ-033 bus_ack outside BUSY SHALL be ignored.
REQ-034 RESP: mem_rvalid=1, mem_stall=0 for exactly one cycle, then IDLE.
REQ-035 The next access can start in the cycle after RESP; minimum latency is 3 cycles from an aligned mem_valid to mem_rvalid with an immediate ack.
REQ-036 Stores: mem_rdata=0 in RESP.
REQ-037 Reserved st_type with mem_we=1: byteen=0000, bus cycle still run.

Reset
REQ-038 reset_n low asynchronously forces IDLE; counter=0; bus_req, bus_we, bus_byteen, mem_rvalid, exc_bus = 0; bus_addr, bus_wdata, mem_rdata = 0.
REQ-039 Reset mid-BUSY abandons the transfer; no mem_rvalid is produced.

Structure
REQ-040 Package lsu_pkg SHALL hold the state enum and the LD_*/ST_* type constants.
REQ-041 Sub-module lsu_load_align SHALL contain the combinational byte/halfword select and extension.

Verification
REQ-042 lb addr 0x0000_0003, ack after 2 cycles, rdata 0x80FF_FFFF -> mem_rdata 0xFFFF_FF80, mem_rvalid 1 cycle, stall covers the wait.
REQ-043 sh addr 0x0000_0002, wdata 0x0000_BEEF -> bus_byteen 1100, bus_wdata 0xBEEF_BEEF, bus_addr 0x0000_0000.
REQ-044 lw addr 0x0000_0006 -> exc_adel=1 in the same cycle, bus_req never asserts, stall 0.
REQ-045 TIMEOUT_CYCLES=4, no ack -> exc_bus=1 with mem_rvalid after 4 BUSY cycles, mem_rdata 0; then a lhu with immediate ack on 0x1234_5678 at addr 2 -> 0x0000_1234.
REQ-046 reset_n low during BUSY -> bus_req=0 immediately, no mem_rvalid; a later ack is ignored.
